// File: rtl/polar_encoder_serial.sv
// Serial non-systematic polar encoder: x = u * F^(kron n).
// The info bits are loaded serially, the butterfly network runs one stage per clock, and the codeword is streamed out serially.
module polar_encoder_serial #(
  parameter int N = 8,
  parameter int LOG2N = 3,
  parameter int K = 4,
  parameter logic [N-1:0] FROZEN_MASK = 8'b0001_0111
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_bit,
  output logic out_valid,
  input  logic out_ready,
  output logic out_bit,
  output logic out_last,
  output logic busy
);

  localparam int CW = $clog2(K + 1);
  localparam int SW = (LOG2N > 1) ? $clog2(LOG2N) : 1;
  localparam int NFROZEN = $countones(FROZEN_MASK);

  generate
    if (N < 2 || N != (1 << LOG2N)) begin : g_bad_n
      $error("polar_encoder_serial: N must be 2**LOG2N and >= 2");
    end
    if (K < 1 || K > N) begin : g_bad_k
      $error("polar_encoder_serial: K must be in 1..N");
    end
    if (NFROZEN != N - K) begin : g_bad_mask
      $error("polar_encoder_serial: popcount(FROZEN_MASK) must be N-K");
    end
  endgenerate

  typedef enum logic [1:0] {
    LOAD,
    ENCODE,
    OUTPUT
  } state_t;

  state_t           state, state_n;
  logic [N-1:0]     v, v_n, v_bfly;
  logic [CW-1:0]    cnt, cnt_n;
  logic [SW-1:0]    stage, stage_n;
  logic [LOG2N-1:0] idx, idx_n;
  logic             in_ready_n;
  logic             out_valid_n;
  logic             out_bit_n;
  logic             out_last_n;
  logic             busy_n;

  // k-th non-frozen position, in ascending index order
  function automatic logic [LOG2N-1:0] slot_of(input logic [CW-1:0] k);
    int c;
    slot_of = '0;
    c = 0;
    for (int i = 0; i < N; i++) begin
      if (!FROZEN_MASK[i]) begin
        if (c == int'(k)) slot_of = LOG2N'(i);
        c++;
      end
    end
  endfunction

  always_comb begin
    v_bfly = v;
    for (int i = 0; i < N; i++) begin
      if (((i >> stage) & 1) == 0)
        v_bfly[i] = v[i] ^ v[i | (1 << stage)];
    end
  end

  always_comb begin
    state_n     = state;
    v_n         = v;
    cnt_n       = cnt;
    stage_n     = stage;
    idx_n       = idx;
    in_ready_n  = in_ready;
    out_valid_n = out_valid;
    out_bit_n   = out_bit;
    out_last_n  = out_last;
    unique case (state)
      LOAD: begin
        in_ready_n = 1'b1;
        if (in_valid && in_ready) begin
          v_n[slot_of(cnt)] = in_bit;
          cnt_n = cnt + 1'b1;
          if (cnt == CW'(K - 1)) begin
            state_n    = ENCODE;
            in_ready_n = 1'b0;
            stage_n    = '0;
          end
        end
      end
      ENCODE: begin
        v_n     = v_bfly;
        stage_n = stage + 1'b1;
        if (stage == SW'(LOG2N - 1)) begin
          state_n = OUTPUT;
          stage_n = '0;
          idx_n   = '0;
        end
      end
      OUTPUT: begin
        // first OUTPUT cycle only primes the output register
        if (!out_valid) begin
          out_valid_n = 1'b1;
          out_bit_n   = v[idx];
          out_last_n  = (idx == LOG2N'(N - 1));
        end else if (out_ready) begin
          if (out_last) begin
            state_n     = LOAD;
            v_n         = '0;
            cnt_n       = '0;
            idx_n       = '0;
            out_valid_n = 1'b0;
            out_bit_n   = 1'b0;
            out_last_n  = 1'b0;
            in_ready_n  = 1'b1;
          end else begin
            idx_n      = idx + 1'b1;
            out_bit_n  = v[idx_n];
            out_last_n = (idx_n == LOG2N'(N - 1));
          end
        end
      end
      default: state_n = LOAD;
    endcase
    busy_n = (state_n != LOAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      v         <= '0;
      cnt       <= '0;
      stage     <= '0;
      idx       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      v         <= v_n;
      cnt       <= cnt_n;
      stage     <= stage_n;
      idx       <= idx_n;
      in_ready  <= in_ready_n;
      out_valid <= out_valid_n;
      out_bit   <= out_bit_n;
      out_last  <= out_last_n;
      busy      <= busy_n;
    end
  end

endmodule

// File: tb/tb_polar_encoder_serial.sv
// Scoreboard bench for polar_encoder_serial.
// An independent subset-parity model produces the expected codewords.
module tb_polar_encoder_serial;

  localparam int N = 8;
  localparam int LOG2N = 3;
  localparam int K = 4;
  localparam logic [N-1:0] MASK = 8'b0001_0111;

  logic clk = 0;
  logic rst = 1;
  logic in_valid = 0;
  logic in_ready;
  logic in_bit = 0;
  logic out_valid;
  logic out_ready = 1;
  logic out_bit;
  logic out_last;
  logic busy;

  polar_encoder_serial #(
    .N(N), .LOG2N(LOG2N), .K(K), .FROZEN_MASK(MASK)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_bit(out_bit), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int popped = 0;
  bit lat_pending = 0;
  bit throttle = 0;
  bit prev_stall = 0;
  logic [2:0] prev_vals = '0;
  logic [1:0] sb[$];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] model(input logic [K-1:0] info);
    logic [N-1:0] u, x;
    int k;
    u = '0;
    x = '0;
    k = 0;
    for (int i = 0; i < N; i++)
      if (!MASK[i]) begin
        u[i] = info[k];
        k++;
      end
    for (int j = 0; j < N; j++)
      for (int i = 0; i < N; i++)
        if ((i & j) == j) x[j] = x[j] ^ u[i];
    return x;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    out_ready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (lat_pending && out_valid) begin
        chk("latency", cyc - acc_cyc, LOG2N + 1);
        lat_pending = 0;
      end
      if (prev_stall)
        chk("hold", int'({out_valid, out_bit, out_last}), int'(prev_vals));
      prev_stall = out_valid && !out_ready;
      prev_vals = {out_valid, out_bit, out_last};
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_empty", 1, 0);
        end else begin
          logic [1:0] e;
          e = sb.pop_front();
          chk("bit", int'(out_bit), int'(e[1]));
          chk("last", int'(out_last), int'(e[0]));
        end
        popped++;
      end
    end else begin
      prev_stall = 0;
    end
  end

  task automatic push_exp(input logic [K-1:0] info);
    logic [N-1:0] x;
    x = model(info);
    for (int j = 0; j < N; j++)
      sb.push_back({x[j], 1'(j == N - 1)});
  endtask

  task automatic send(input logic [K-1:0] info, input int hold);
    int g;
    push_exp(info);
    for (int k = 0; k < K; k++) begin
      in_valid = 1;
      in_bit = info[k];
      g = 0;
      while (!in_ready && g < 200) begin
        @(negedge clk);
        g++;
      end
      if (!in_ready) chk("in_ready_timeout", 0, 1);
      @(negedge clk);
      if (k == K - 1) begin
        acc_cyc = cyc;
        lat_pending = 1;
      end
    end
    in_bit = 1;
    for (int h = 0; h < hold; h++) begin
      chk("no_extra_accept", int'(in_ready), 0);
      @(negedge clk);
    end
    in_valid = 0;
    in_bit = 0;
  endtask

  task automatic drain;
    int g;
    g = 0;
    while ((sb.size() != 0 || busy) && g < 500) begin
      @(negedge clk);
      g++;
    end
    chk("drain", sb.size(), 0);
  endtask

  task automatic do_reset;
    rst = 1;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_bit", int'(out_bit), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_busy", int'(busy), 0);
    sb.delete();
    lat_pending = 0;
    rst = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_in_ready", int'(in_ready), 1);
      chk("idle_out_valid", int'(out_valid), 0);
      chk("idle_busy", int'(busy), 0);
    end

    send(4'b1111, 3);
    drain();
    send(4'b0001, 0);
    drain();
    send(4'b1000, 0);
    send(4'b0000, 0);
    drain();

    throttle = 1;
    send(4'b1111, 0);
    drain();
    send(4'b1011, 0);
    drain();
    throttle = 0;
    @(negedge clk);

    // reset during ENCODE stage 1
    send(4'b1111, 0);
    @(negedge clk);
    do_reset();
    send(4'b0001, 0);
    drain();

    // reset during OUTPUT after three bits
    popped = 0;
    send(4'b1111, 0);
    begin
      int g;
      g = 0;
      while (popped < 3 && g < 100) begin
        @(negedge clk);
        g++;
      end
      chk("reach_output", int'(popped >= 3), 1);
    end
    do_reset();
    @(negedge clk);
    chk("post_rst_out_valid", int'(out_valid), 0);
    send(4'b0001, 0);
    drain();

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/polar_encoder_serial.md
Name: polar_encoder_serial

Overview:
- Systematic-free (non-systematic) polar encoder: x = u·F^{⊗n}, with F = [[1,0],[1,1]].
- The encoder side of the SC decoder datapath that the LLR f/g units serve.
- Accepts K information bits serially, inserts frozen zeros per a parameter mask, and runs LOG2N in-place butterfly stages (one per clock).
- Streams the N-bit codeword out serially with valid/ready backpressure.
- Used to generate test codewords and for the rateless transmit path.

Parameters:
- N, 8, code length; power of 2, ≥2.
- LOG2N, 3, log2(N); must match N; checked at elaboration.
- K, 4, information bits per codeword; 1..N.
- FROZEN_MASK, 8'b0001_0111, N-bit mask; bit i=1 means u[i] is frozen (forced 0). Popcount must equal N-K; checked at elaboration.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  in_bit is valid this cycle
- in_ready  out  1  encoder accepts an info bit this cycle
- in_bit  in  1  information bit
- out_valid  out  1  out_bit is valid
- out_ready  in  1  downstream accepts out_bit
- out_bit  out  1  codeword bit x[idx], index 0 first
- out_last  out  1  high with x[N-1]
- busy  out  1  high in ENCODE or OUTPUT

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_bit=0, out_last=0, busy=0. Codeword register v[N-1:0] cleared. State=LOAD, counters=0. in_ready rises on the first cycle after rst deasserts.
- Reset has priority over all events, including mid-LOAD, mid-ENCODE and mid-OUTPUT. A partial codeword is discarded; no output is produced for it.
- State LOAD: in_ready=1. On in_valid&in_ready:
  - Write in_bit into v at the next non-frozen index, in ascending order. The first accepted bit goes to the lowest index with FROZEN_MASK[i]=0.
  - Frozen positions hold 0.
  - Info counter increments.
  - On acceptance of the K-th bit: go to ENCODE; in_ready=0 from the next cycle.
- State ENCODE: exactly LOG2N cycles, stage s = 0..LOG2N-1.
  - Each stage: for every i with bit s of i clear, v[i] <= v[i] ^ v[i | 2^s]. Entries with bit s set are unchanged.
  - After stage LOG2N-1: go to OUTPUT.
  - in_valid is ignored here; in_ready=0.
- State OUTPUT:
  - out_valid=1 and out_bit=v[idx], with idx starting at 0.
  - On out_valid&out_ready: idx++. out_last=1 while idx==N-1.
  - Handshake on idx==N-1: go to LOAD; out_valid=0 and in_ready=1 in the next cycle. Clear v and all counters.
  - out_ready low: out_valid, out_bit and out_last hold stable (no bubble, no change) until accepted.
- Latency: the first out_valid cycle is LOG2N+1 clocks after the cycle in which the K-th in_bit is accepted (LOG2N encode cycles plus one registered-output cycle).
  - With out_ready tied high, OUTPUT lasts N cycles.
  - Minimum codeword period is K+LOG2N+1+N cycles. There is no overlap between codewords.
- All outputs are registered.
- Counter widths: info counter $clog2(K+1); output index LOG2N bits; no wrap inside a codeword.
- Mask lookup: a combinational next-free-index scan over FROZEN_MASK, or a precomputed constant table; either is acceptable.
- in_valid held high across the LOAD→ENCODE boundary: the extra bits are not consumed (in_ready=0).

Test Plan:
- Reset, then idle 5 cycles -> in_ready=1 from first post-reset cycle; out_valid=0, busy=0 throughout.
- Info bits 1,1,1,1, out_ready=1 -> u has 1s at positions 3,5,6,7. Output x[0..7]=0,1,1,0,1,0,0,1; out_last only on the 8th bit; first out_valid exactly 4 cycles after the 4th accept.
- Info bits 1,0,0,0 (u[3]=1 only) -> x=1,1,1,1,0,0,0,0.
- Info bits 0,0,0,1 (u[7]=1 only) -> x=1,1,1,1,1,1,1,1. Then info 0,0,0,0 -> x=all zeros: back-to-back codewords, no stale state.
- Random out_ready throttling (≈50%) on the all-ones vector -> same sequence 0,1,1,0,1,0,0,1; out_bit and out_last stable while out_valid&!out_ready.
- Assert rst during ENCODE stage 1, and separately during OUTPUT after 3 bits sent -> all outputs go to reset values next cycle. The next codeword (1,0,0,0) encodes correctly to 1,1,1,1,0,0,0,0.
